// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 16 x W register file with two combinational read ports,
//                write-to-read bypass, r0 hardwired to zero, and a
//                valid/ready serial dump engine that streams r0..r15.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [3:0]   wa,
    input  logic [W-1:0] wd,
    input  logic [3:0]   ra1,
    input  logic [3:0]   ra2,
    output logic [W-1:0] rd1,
    output logic [W-1:0] rd2,
    input  logic         dump_start,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [3:0]   dump_addr,
    output logic [W-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_ADDR = 4'd15;

    logic [W-1:0] r_regs [16];

    state_t       r_state;
    logic         r_dump_valid;
    logic [3:0]   r_dump_addr;
    logic [W-1:0] r_dump_data;
    logic         r_dump_busy;
    logic         r_dump_done;

    logic         w_wr_hit;
    logic         w_xfer;
    logic [3:0]   w_next_addr;
    logic [W-1:0] w_next_data;

    // A write to r0 is a no-op, so only non-zero addresses count as hits.
    assign w_wr_hit = we && (wa != 4'd0);

    // Value a register will hold after this edge: r0 is always zero and a
    // same-cycle write to the addressed register is forwarded.
    function automatic logic [W-1:0] read_bypass(input logic [3:0] addr);
        logic [W-1:0] v;
        if (addr == 4'd0) begin
            v = '0;
        end else if (w_wr_hit && (wa == addr)) begin
            v = wd;
        end else begin
            v = r_regs[addr];
        end
        return v;
    endfunction

    assign rd1 = read_bypass(ra1);
    assign rd2 = read_bypass(ra2);

    assign w_xfer      = r_dump_valid && dump_ready;
    assign w_next_addr = r_dump_addr + 4'd1;
    assign w_next_data = read_bypass(w_next_addr);

    // Register storage: cleared by reset, one decoded write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[wa] <= wd;
        end
    end

    // Dump engine: word snapshot is captured on entry/advance and held
    // through stalls, so later writes do not disturb a pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= 4'd0;
            r_dump_data  <= '0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dump_done <= 1'b0;
                    if (dump_start) begin
                        r_state      <= ST_SEND;
                        r_dump_valid <= 1'b1;
                        r_dump_busy  <= 1'b1;
                        r_dump_addr  <= 4'd0;
                        r_dump_data  <= read_bypass(4'd0);
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (r_dump_addr == C_LAST_ADDR) begin
                            r_state      <= ST_DONE;
                            r_dump_valid <= 1'b0;
                            r_dump_done  <= 1'b1;
                        end else begin
                            r_dump_addr <= w_next_addr;
                            r_dump_data <= w_next_data;
                        end
                    end
                end
                ST_DONE: begin
                    // dump_start is deliberately ignored here.
                    r_state      <= ST_IDLE;
                    r_dump_done  <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_valid <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_dump_valid <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_done  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_busy  = r_dump_busy;
    assign dump_done  = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Self-checking bench for reg_file: table-driven read/write
//                vectors plus directed dump, stall and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         we;
    logic [3:0]   wa;
    logic [W-1:0] wd;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic         dump_start;
    logic         dump_valid;
    logic         dump_ready;
    logic [3:0]   dump_addr;
    logic [W-1:0] dump_data;
    logic         dump_busy;
    logic         dump_done;

    int n_cmp;
    int n_fail;
    int done_cnt;

    reg_file #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count dump_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (dump_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic         we;
        logic [3:0]   wa;
        logic [W-1:0] wd;
        logic [3:0]   ra1;
        logic [3:0]   ra2;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check_all_zero_reads;
        for (int k = 0; k < 16; k++) begin
            tick;
            ra1 = 4'(k);
            ra2 = 4'(15 - k);
            #1;
            check("zero_rd1", rd1, 0);
            check("zero_rd2", rd2, 0);
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        dump_ready = 1'b1;
        while (dump_busy !== 1'b0 && n < 40) begin
            tick;
            n++;
        end
        #1;
        check("drain_busy", dump_busy, 0);
    endtask

    task automatic run_dump(input bit poke);
        int d0;
        d0 = done_cnt;
        tick;
        we = 1'b0; dump_start = 1'b1; dump_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            dump_start = poke && (i == 4 || i == 9);
            #1;
            check("dump_valid", dump_valid, 1);
            check("dump_addr", dump_addr, i);
            check("dump_data", dump_data, 32'(i * 17));
        end
        tick;
        dump_start = poke;
        #1;
        check("done_pulse", dump_done, 1);
        check("done_busy", dump_busy, 1);
        check("done_valid", dump_valid, 0);
        tick;
        dump_start = 1'b0;
        #1;
        check("after_done", dump_done, 0);
        check("after_busy", dump_busy, 0);
        tick;
        #1;
        check("idle_busy", dump_busy, 0);
        check("idle_valid", dump_valid, 0);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; done_cnt = 0;
        reset = 1'b1; we = 1'b1; wa = 4'd5; wd = 16'hFFFF;
        ra1 = 4'd0; ra2 = 4'd0; dump_start = 1'b1; dump_ready = 1'b0;

        vecs[0] = '{1'b1, 4'd5,  16'h1234, 4'd5,  4'd0,  16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  16'h1234, 16'h1234};
        vecs[2] = '{1'b1, 4'd0,  16'hFFFF, 4'd5,  4'd0,  16'h1234, 16'h0000};
        vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 4'd7,  16'hBEEF, 4'd7,  4'd5,  16'hBEEF, 16'h1234};
        vecs[5] = '{1'b0, 4'd0,  16'h0000, 4'd7,  4'd7,  16'hBEEF, 16'hBEEF};
        vecs[6] = '{1'b1, 4'd15, 16'hA5A5, 4'd14, 4'd15, 16'h0000, 16'hA5A5};
        vecs[7] = '{1'b1, 4'd5,  16'h0001, 4'd5,  4'd15, 16'h0001, 16'hA5A5};
        vecs[8] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd1,  16'h0001, 16'h0000};

        // Reset wins over simultaneous write and dump_start.
        tick; tick;
        #1;
        check("rst_valid", dump_valid, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_done", dump_done, 0);
        tick;
        reset = 1'b0; we = 1'b0; dump_start = 1'b0;
        #1;
        check("post_rst_valid", dump_valid, 0);
        check("post_rst_busy", dump_busy, 0);
        check("post_rst_done", dump_done, 0);
        check("post_rst_addr", dump_addr, 0);
        check("post_rst_data", dump_data, 0);
        check_all_zero_reads;

        // Table-driven read/write/bypass vectors.
        for (int i = 0; i < 9; i++) begin
            tick;
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            check("vec_rd1", rd1, vecs[i].e1);
            check("vec_rd2", rd2, vecs[i].e2);
        end

        // Preload rK = K*0x11.
        for (int k = 1; k < 16; k++) begin
            tick;
            we = 1'b1; wa = 4'(k); wd = 16'(k * 17);
        end
        tick;
        we = 1'b0;

        run_dump(1'b0);
        run_dump(1'b1);

        // Stall at addr 3 while r3 is rewritten, then bypass into addr 4.
        tick;
        dump_start = 1'b1; dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            dump_start = 1'b0;
            if (i == 3) begin
                dump_ready = 1'b0;
                we = 1'b1; wa = 4'd3; wd = 16'hAAAA;
            end
            #1;
            check("stall_pre_addr", dump_addr, i);
        end
        check("stall_pre_data", dump_data, 16'h0033);
        for (int s = 0; s < 5; s++) begin
            tick;
            we = 1'b0;
            ra1 = 4'd3;
            if (s == 4) begin
                dump_ready = 1'b1;
                we = 1'b1; wa = 4'd4; wd = 16'h4444;
            end
            #1;
            check("stall_addr", dump_addr, 3);
            check("stall_data", dump_data, 16'h0033);
            check("stall_valid", dump_valid, 1);
        end
        check("stall_r3_read", rd1, 16'hAAAA);
        tick;
        we = 1'b0;
        #1;
        check("resume_addr", dump_addr, 4);
        check("resume_bypass_data", dump_data, 16'h4444);
        drain;
        tick;
        ra1 = 4'd3;
        #1;
        check("later_r3_read", rd1, 16'hAAAA);

        // Reset in the middle of a dump at addr 9.
        tick;
        dump_start = 1'b1; dump_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            dump_start = 1'b0;
            #1;
            check("pre_abort_addr", dump_addr, i);
            if (i == 9) reset = 1'b1;
        end
        begin
            int d0;
            d0 = done_cnt;
            tick;
            reset = 1'b0;
            #1;
            check("abort_valid", dump_valid, 0);
            check("abort_busy", dump_busy, 0);
            check("abort_done", dump_done, 0);
            check("abort_addr", dump_addr, 0);
            check("abort_data", dump_data, 0);
            check_all_zero_reads;
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_still_idle", dump_busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
